// File: rtl/adder_pkg.sv
// adder_pkg -- shared types and constants for the adder bus driver.
//   state_t       : driver FSM states (IDLE / DRIVE / HOLD)
//   DEFAULT_WIDTH : default operand/sum width
//   SETTLE_MAX    : largest legal settle time in cycles
//   CNT_W         : settle down-counter width (holds 0..SETTLE_MAX)
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int SETTLE_MAX    = 15;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/adder_ref_chk.sv
// adder_ref_chk -- reference check of the external adder's result.
// On each capture strobe the bus result {bus_carry,bus_sum} is compared with
// a local WIDTH+1-bit sum of the driven operands. A mismatch sets a sticky
// flag and bumps a saturating 8-bit error count. Only reset clears either.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   check               capture strobe (one cycle per transfer)
//   bus_a, bus_b        operands currently driven onto the adder bus
//   bus_sum, bus_carry  result returned by the adder
//   err_flag            sticky mismatch flag
//   err_count           mismatch count, saturates at 255
module adder_ref_chk
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             check,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [WIDTH-1:0] bus_sum,
    input  logic             bus_carry,
    output logic             err_flag,
    output logic [7:0]       err_count
);

    logic [WIDTH:0] ref_sum;
    logic           mismatch;

    assign ref_sum  = {1'b0, bus_a} + {1'b0, bus_b};
    assign mismatch = (ref_sum != {bus_carry, bus_sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag  <= 1'b0;
            err_count <= 8'd0;
        end else if (check && mismatch) begin
            err_flag <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/adder_driver.sv
// adder_driver -- drives operand pairs onto an external combinational adder
// bus, waits SETTLE cycles, captures the result and offers it downstream
// with a valid/ready handshake.
//
// Optional feature (macro ADDER_DRIVER_CHECK_EN): adds err_flag/err_count
// outputs fed by adder_ref_chk, which cross-checks each captured result.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake; in_ready only in IDLE
//   in_a, in_b          operands (unsigned)
//   bus_a, bus_b        registered drive to the adder; held until next accept
//   bus_sum, bus_carry  adder result
//   out_valid/out_ready result handshake; out_valid only in HOLD
//   out_sum, out_carry  captured result
//   err_flag, err_count (ADDER_DRIVER_CHECK_EN only)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for operands (after first post-reset edge)
// DRIVE | operands on bus, settle counter running down to zero
// HOLD  | result captured, out_valid high until out_ready
module adder_driver
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] bus_a,
    output logic [WIDTH-1:0] bus_b,
    input  logic [WIDTH-1:0] bus_sum,
    input  logic             bus_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
`ifdef ADDER_DRIVER_CHECK_EN
    ,
    output logic             err_flag,
    output logic [7:0]       err_count
`endif
);

    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("adder_driver: SETTLE must be in 1..15");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             accept;
    logic             capture;
    logic             cnt_tc;

    // Counter reaches zero on the edge where it currently holds 1.
    assign cnt_tc = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && run) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_tc) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // run keeps in_ready low while reset is asserted and until the first
    // clock edge after release, even though the state is already IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bus_a     <= '0;
            bus_b     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            if (accept) begin
                bus_a <= in_a;
                bus_b <= in_b;
                cnt   <= CNT_W'(SETTLE);
            end else if (state == DRIVE) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                out_sum   <= bus_sum;
                out_carry <= bus_carry;
            end
        end
    end

    assign in_ready  = run && (state == IDLE);
    assign out_valid = (state == HOLD);

`ifdef ADDER_DRIVER_CHECK_EN
    adder_ref_chk #(
        .WIDTH (WIDTH)
    ) u_ref_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .check     (capture),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .bus_sum   (bus_sum),
        .bus_carry (bus_carry),
        .err_flag  (err_flag),
        .err_count (err_count)
    );
`endif

endmodule

// File: tb/tb_adder_driver.sv
// tb_adder_driver -- directed bench for adder_driver (WIDTH=4).
// u_dut runs SETTLE=1 with a bench adder that can be made faulty (sum^1);
// u_dut3 runs SETTLE=3 with a correct adder. Define ADDER_DRIVER_CHECK_EN
// to include the error-counter checks.
module tb_adder_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fault = 1'b0;

    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, out_carry, bus_carry;
    logic [3:0] bus_a, bus_b, bus_sum, out_sum;

    logic       in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic [3:0] in_a3 = '0, in_b3 = '0;
    logic       in_ready3, out_valid3, out_carry3, bus_carry3;
    logic [3:0] bus_a3, bus_b3, bus_sum3, out_sum3;

`ifdef ADDER_DRIVER_CHECK_EN
    logic       err_flag, err_flag3;
    logic [7:0] err_count, err_count3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign {bus_carry, bus_sum}   = ({1'b0, bus_a} + {1'b0, bus_b}) ^ {4'b0000, fault};
    assign {bus_carry3, bus_sum3} = {1'b0, bus_a3} + {1'b0, bus_b3};

    adder_driver #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .bus_sum   (bus_sum),
        .bus_carry (bus_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
`ifdef ADDER_DRIVER_CHECK_EN
        ,
        .err_flag  (err_flag),
        .err_count (err_count)
`endif
    );

    adder_driver #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_a      (in_a3),
        .in_b      (in_b3),
        .bus_a     (bus_a3),
        .bus_b     (bus_b3),
        .bus_sum   (bus_sum3),
        .bus_carry (bus_carry3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_sum   (out_sum3),
        .out_carry (out_carry3)
`ifdef ADDER_DRIVER_CHECK_EN
        ,
        .err_flag  (err_flag3),
        .err_count (err_count3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One SETTLE=1 transfer with immediate out_ready in HOLD.
    task automatic xfer(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] es, input logic ec);
        in_a = a; in_b = b; in_valid = 1'b1;
        check("ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bus_a_drv", bus_a, a);
        check("bus_b_drv", bus_b, b);
        check("valid_in_drive", out_valid, 0);
        check("ready_in_drive", in_ready, 0);
        tick();
        check("valid_in_hold", out_valid, 1);
        check("sum", out_sum, es);
        check("carry", out_carry, ec);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after", out_valid, 0);
        check("ready_after", in_ready, 1);
        check("bus_a_kept", bus_a, a);
        check("bus_b_kept", bus_b, b);
    endtask

    initial begin
        // reset state
        #3;
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_bus_a", bus_a, 0);
        check("rst_sum", out_sum, 0);
        #10 rst_n = 1'b1;
        check("ready_before_edge", in_ready, 0);
        tick();
        check("ready_first_edge", in_ready, 1);
        check("ready3_first_edge", in_ready3, 1);

        // main function
        xfer(4'b0010, 4'b0001, 4'b0011, 1'b0);
        xfer(4'b1111, 4'b0001, 4'b0000, 1'b1);
        xfer(4'b1111, 4'b1111, 4'b1110, 1'b1);
        xfer(4'b0000, 4'b0000, 4'b0000, 1'b0);
        xfer(4'b1000, 4'b1000, 4'b0000, 1'b1);

        // out_ready high outside HOLD is ignored
        out_ready = 1'b1;
        in_a = 4'd6; in_b = 4'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ordy_drive_valid", out_valid, 0);
        tick();
        check("ordy_hold_valid", out_valid, 1);
        check("ordy_sum", out_sum, 4'd13);
        tick();
        out_ready = 1'b0;
        check("ordy_back_idle", in_ready, 1);

        // HOLD with out_ready low for 5 cycles; new operands ignored
        in_a = 4'd3; in_b = 4'd4; in_valid = 1'b1;
        tick();
        in_a = 4'd9; in_b = 4'd9;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, 4'd7);
            check("hold_carry", out_carry, 0);
            check("hold_ready", in_ready, 0);
            check("hold_bus_a", bus_a, 4'd3);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release", out_valid, 0);
        check("hold_bus_b", bus_b, 4'd4);

        // reset pulse during DRIVE discards the result
        in_a = 4'd5; in_b = 4'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_drive", out_valid, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bus_a", bus_a, 0);
        check("mid_rst_bus_b", bus_b, 0);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_carry", out_carry, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        tick();
        check("post_rst_valid2", out_valid, 0);
        check("post_rst_sum", out_sum, 0);

        // SETTLE=3 latency: capture at E0+3, valid from the cycle after
        in_a3 = 4'b0101; in_b3 = 4'b0011; in_valid3 = 1'b1;
        check("s3_ready", in_ready3, 1);
        tick();
        in_valid3 = 1'b0;
        for (int i = 1; i < 3; i++) begin
            check("s3_not_yet", out_valid3, 0);
            tick();
        end
        check("s3_not_yet_e2", out_valid3, 0);
        tick();
        check("s3_valid", out_valid3, 1);
        check("s3_sum", out_sum3, 4'b1000);
        check("s3_carry", out_carry3, 0);
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        check("s3_done", out_valid3, 0);

`ifdef ADDER_DRIVER_CHECK_EN
        check("err_clean", err_count, 0);
        check("err_flag_clean", err_flag, 0);
        fault = 1'b1;
        xfer(4'b0010, 4'b0001, 4'b0010, 1'b0);
        check("err_flag_1", err_flag, 1);
        check("err_count_1", err_count, 1);
        xfer(4'b0100, 4'b0100, 4'b1001, 1'b0);
        check("err_flag_2", err_flag, 1);
        check("err_count_2", err_count, 2);
        fault = 1'b0;
        xfer(4'b0001, 4'b0001, 4'b0010, 1'b0);
        check("err_count_kept", err_count, 2);
        check("err3_clean", err_count3, 0);
        check("err3_flag_clean", err_flag3, 0);
        rst_n = 1'b0;
        #2;
        check("err_rst_flag", err_flag, 0);
        check("err_rst_count", err_count, 0);
        rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_driver.md
ADDER_DRIVER -- requirements
Module: adder_driver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-002 Parameter WIDTH SHALL be provided: default 4, operand/sum width.
REQ-003 Parameter SETTLE SHALL be provided: default 1, adder settle cycles; legal range 1..15; any other value SHALL fail elaboration.
REQ-004 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n SHALL be: input, 1 bit, async active-low reset.
REQ-006 Port in_valid SHALL be: input, 1 bit, operand pair offered.
REQ-007 Port in_ready SHALL be: output, 1 bit, driver accepts operands.
REQ-008 Ports in_a and in_b SHALL be: input, WIDTH bits each, operands.
REQ-009 Ports bus_a and bus_b SHALL be: output, WIDTH bits each, registered drive to the adder bus a/b.
REQ-010 Port bus_sum SHALL be: input, WIDTH bits, adder bus sum.
REQ-011 Port bus_carry SHALL be: input, 1 bit, adder bus carry.
REQ-012 Port out_valid SHALL be: output, 1 bit, result available.
REQ-013 Port out_ready SHALL be: input, 1 bit, consumer accepts result.
REQ-014 Port out_sum SHALL be: output, WIDTH bits, captured sum.
REQ-015 Port out_carry SHALL be: output, 1 bit, captured carry.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on in_valid&&in_ready at edge E0, the block SHALL register in_a/in_b into bus_a/bus_b, load the settle counter to SETTLE, and go to DRIVE.
REQ-018 DRIVE: the counter SHALL decrement each edge; at the edge where it reaches 0 (E0+SETTLE), the block SHALL capture bus_sum/bus_carry into out_sum/out_carry and go to HOLD.
REQ-019 HOLD: out_valid SHALL be 1; out_sum/out_carry SHALL be stable; on out_ready the block SHALL return to IDLE at that edge.
REQ-020 Latency: out_valid SHALL rise in the cycle following edge E0+SETTLE; there is no IDLE bypass, so peak throughput is one transfer per SETTLE+2 cycles.
REQ-021 bus_a/bus_b SHALL hold their last values until the next acceptance.
REQ-022 in_valid outside IDLE SHALL be ignored with no side effect.
REQ-023 out_ready outside HOLD SHALL be ignored.
REQ-024 Operands SHALL be unsigned; the carry SHALL be bit WIDTH of the sum, with no overflow flag.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, counter 0, bus_a/bus_b 0, out_sum/out_carry 0, out_valid 0, in_ready 0 while asserted.
REQ-026 Reset mid-DRIVE or mid-HOLD SHALL discard the pending result with no output produced.
REQ-027 After deassertion, in_ready SHALL be 1 from the first clk edge onward.

Configuration
REQ-028 When macro ADDER_DRIVER_CHECK_EN is defined, the block SHALL add outputs err_flag (1 bit, sticky) and err_count (8 bits, saturates at 255).
REQ-029 With ADDER_DRIVER_CHECK_EN, at the capture edge the block SHALL compare {bus_carry,bus_sum} against the WIDTH+1-bit sum of bus_a+bus_b, and on mismatch set err_flag and increment err_count.
REQ-030 With ADDER_DRIVER_CHECK_EN, err_flag and err_count SHALL be cleared only by reset.
REQ-031 Without ADDER_DRIVER_CHECK_EN, the ports and check logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package adder_pkg SHALL hold the state enum (IDLE/DRIVE/HOLD), DEFAULT_WIDTH=4, SETTLE_MAX=15 and the counter width constant (4).
REQ-033 The reference comparison SHALL be in sub-module adder_ref_chk, instantiated only under ADDER_DRIVER_CHECK_EN.

Verification (WIDTH=4, SETTLE=1, bench models the combinational adder on the bus unless stated)
REQ-034 The bench SHALL cover: a=0010, b=0001 accepted -> out_valid next-but-one cycle, out_sum=0011, out_carry=0.
REQ-035 The bench SHALL cover: a=1111, b=0001 -> out_sum=0000, out_carry=1; a=1111, b=1111 -> out_sum=1110, out_carry=1.
REQ-036 The bench SHALL cover: out_ready held low 5 cycles in HOLD -> out_valid/out_sum stable, in_ready 0 throughout, and a new in_valid pair ignored.
REQ-037 The bench SHALL cover: rst_n pulsed low during DRIVE -> no out_valid, all outputs 0, in_ready 1 after release.
REQ-038 The bench SHALL cover: with ADDER_DRIVER_CHECK_EN and a faulty adder model returning sum^0001, 2+1 -> out_sum=0010, err_flag=1, err_count=1; a second transfer -> err_count=2.
REQ-039 The bench SHALL cover: SETTLE=3, a=0101, b=0011 -> out_valid rises 4 cycles after the acceptance edge, out_sum=1000, out_carry=0.
